// File: rtl/multi_servo_pwm_controller.sv
// Multi-channel hobby-servo PWM generator: one shared frame timer, per-channel
// shadow/active position registers committed together at each frame start.
`timescale 1ns/1ps
module multi_servo_pwm_controller #(
  parameter int C_NUM_CH     = 3,
  parameter int C_PWM_SIZE   = 8,
  parameter int C_CLK_FREQ   = 100,
  parameter int C_PWM_MAX_IN = 200,
  parameter int C_MIN_US     = 500,
  parameter int C_SPAN_US    = 2000,
  parameter int C_FRAME_US   = 20000
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          EN,
  input  logic [C_NUM_CH-1:0]                           CH_EN,
  input  logic                                          WR_VALID,
  output logic                                          WR_READY,
  input  logic [((C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1)-1:0] WR_CH,
  input  logic [C_PWM_SIZE-1:0]                         WR_DATA,
  output logic                                          WR_ERR,
  output logic                                          FRAME_START,
  output logic [C_NUM_CH-1:0]                           PWM_OUT
);

  localparam int N_HEAD  = C_MIN_US * C_CLK_FREQ;
  localparam int N_STEP  = C_SPAN_US * C_CLK_FREQ / C_PWM_MAX_IN;
  localparam int N_SPAN  = C_PWM_MAX_IN * N_STEP;
  localparam int N_FRAME = C_FRAME_US * C_CLK_FREQ;
  localparam int N_TAIL  = N_FRAME - 1 - N_HEAD - N_SPAN;
  localparam int CNT_W   = $clog2(N_FRAME);
  localparam int STEP_W  = (N_STEP > 1) ? $clog2(N_STEP) : 1;

  localparam logic [CNT_W-1:0]      HEAD_LAST = CNT_W'(N_HEAD - 1);
  localparam logic [CNT_W-1:0]      TAIL_LAST = CNT_W'(N_TAIL - 1);
  localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(N_STEP - 1);
  localparam logic [C_PWM_SIZE-1:0] MAX_POS   = C_PWM_SIZE'(C_PWM_MAX_IN);
  localparam logic [C_PWM_SIZE-1:0] IDX_LAST  = C_PWM_SIZE'(C_PWM_MAX_IN - 1);

  typedef enum logic [2:0] {IDLE, COMMIT, HEAD, SPAN, TAIL} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [STEP_W-1:0]     step, step_nxt;
  logic [C_PWM_SIZE-1:0] idx, idx_nxt;
  logic [C_PWM_SIZE-1:0] shadow [C_NUM_CH];
  logic [C_PWM_SIZE-1:0] active [C_NUM_CH];
  logic [C_NUM_CH-1:0]   active_en, en_nxt, pwm_nxt;
  logic                  wr_accept, wr_bad;

  function automatic logic [C_PWM_SIZE-1:0] clamp_pos(input logic [C_PWM_SIZE-1:0] v);
    return (v > MAX_POS) ? MAX_POS : v;
  endfunction

  assign wr_accept = WR_VALID && WR_READY;
  assign wr_bad    = (32'(WR_CH) >= C_NUM_CH);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    step_nxt  = '0;
    idx_nxt   = '0;
    case (state)
      IDLE:   if (EN) state_nxt = COMMIT;
      COMMIT: state_nxt = HEAD;
      HEAD: begin
        if (cnt == HEAD_LAST) state_nxt = SPAN;
        else cnt_nxt = cnt + 1'b1;
      end
      SPAN: begin
        if (step == STEP_LAST) begin
          if (idx == IDX_LAST) state_nxt = TAIL;
          else idx_nxt = idx + 1'b1;
        end else begin
          step_nxt = step + 1'b1;
          idx_nxt  = idx;
        end
      end
      TAIL: begin
        if (cnt == TAIL_LAST) state_nxt = EN ? COMMIT : IDLE;
        else cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered;
  // the enables latched at COMMIT are taken straight from CH_EN on that edge.
  always_comb begin
    en_nxt  = (state == COMMIT) ? CH_EN : active_en;
    pwm_nxt = '0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      case (state_nxt)
        HEAD:    pwm_nxt[i] = en_nxt[i];
        SPAN:    pwm_nxt[i] = active_en[i] && (idx_nxt < active[i]);
        default: pwm_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      step        <= '0;
      idx         <= '0;
      active_en   <= '0;
      shadow      <= '{default: '0};
      active      <= '{default: '0};
      PWM_OUT     <= '0;
      FRAME_START <= 1'b0;
      WR_READY    <= 1'b0;
      WR_ERR      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      step        <= step_nxt;
      idx         <= idx_nxt;
      PWM_OUT     <= pwm_nxt;
      FRAME_START <= (state_nxt == COMMIT);
      WR_READY    <= (state_nxt != COMMIT);
      WR_ERR      <= wr_accept && wr_bad;
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (wr_accept && (32'(WR_CH) == i)) shadow[i] <= clamp_pos(WR_DATA);
      end
      // WR_READY is low during COMMIT, so shadow is stable while it is copied.
      if (state == COMMIT) begin
        active    <= shadow;
        active_en <= CH_EN;
      end
    end
  end

endmodule

// File: tb/tb_multi_servo_pwm_controller.sv
// Directed bench for multi_servo_pwm_controller at 1 MHz with a shortened frame.
`timescale 1ns/1ps
module tb_multi_servo_pwm_controller;

  localparam int FRAME = 4000;

  logic       CLK, RST, EN, WR_VALID, WR_READY, WR_ERR, FRAME_START;
  logic [2:0] CH_EN, PWM_OUT;
  logic [1:0] WR_CH;
  logic [7:0] WR_DATA;

  multi_servo_pwm_controller #(
    .C_NUM_CH(3), .C_PWM_SIZE(8), .C_CLK_FREQ(1), .C_PWM_MAX_IN(200),
    .C_MIN_US(500), .C_SPAN_US(2000), .C_FRAME_US(FRAME)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CH_EN(CH_EN), .WR_VALID(WR_VALID),
    .WR_READY(WR_READY), .WR_CH(WR_CH), .WR_DATA(WR_DATA), .WR_ERR(WR_ERR),
    .FRAME_START(FRAME_START), .PWM_OUT(PWM_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1.5 ms");
    $fatal(1, "watchdog");
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse monitor, sampled 1 ns after each rising edge.
  int cyc = 0, last_fs = 0, period = 0, fs_cnt = 0, gap_err = 0, rise_cnt = 0;
  int hi_cnt[3] = '{0, 0, 0};
  int frame_w[3] = '{0, 0, 0};
  logic [2:0] prev = '0;

  always @(posedge CLK) begin
    #1;
    cyc++;
    if (FRAME_START) begin
      period  = cyc - last_fs;
      last_fs = cyc;
      fs_cnt++;
      for (int i = 0; i < 3; i++) begin
        frame_w[i] = hi_cnt[i];
        hi_cnt[i]  = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (PWM_OUT[i]) hi_cnt[i]++;
      if (PWM_OUT[i] && !prev[i]) begin
        rise_cnt++;
        if (cyc - last_fs != 1) gap_err++;
      end
    end
    prev = PWM_OUT;
  end

  task automatic do_write(input int ch, input int data, output int stalls);
    WR_CH    = 2'(ch);
    WR_DATA  = 8'(data);
    WR_VALID = 1'b1;
    stalls   = 0;
    while (!WR_READY && stalls < 10) begin
      @(negedge CLK);
      stalls++;
    end
    @(negedge CLK);
    WR_VALID = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!FRAME_START && n < FRAME + 100);
    check(name, int'(FRAME_START), 1);
  endtask

  typedef struct {
    int v0, v1, v2;
    logic [2:0] en;
    int w0, w1, w2;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int st, n, fs_t, fs0;
    vecs[0] = '{100, 0,   0,   3'b001, 1500, 0,    0};
    vecs[1] = '{0,   200, 255, 3'b111, 500,  2500, 2500};
    vecs[2] = '{17,  3,   199, 3'b110, 0,    530,  2490};
    vecs[3] = '{200, 1,   100, 3'b101, 2500, 0,    1500};

    RST = 1'b1; EN = 1'b0; CH_EN = '0; WR_VALID = 1'b0; WR_CH = '0; WR_DATA = '0;
    repeat (3) @(negedge CLK);
    check("rst_pwm", int'(PWM_OUT), 0);
    check("rst_frame_start", int'(FRAME_START), 0);
    check("rst_wr_ready", int'(WR_READY), 0);
    check("rst_wr_err", int'(WR_ERR), 0);
    RST = 1'b0;
    #1 check("ready_before_edge", int'(WR_READY), 0);
    @(negedge CLK);
    check("ready_after_release", int'(WR_READY), 1);
    repeat (20) @(negedge CLK);
    check("idle_pwm", int'(PWM_OUT), 0);
    check("idle_no_frames", fs_cnt, 0);

    // Table: values written during frame i-1 are committed for frame i.
    do_write(0, vecs[0].v0, st);
    do_write(1, vecs[0].v1, st);
    do_write(2, vecs[0].v2, st);
    CH_EN = vecs[0].en;
    EN = 1'b1;
    wait_fs("first_frame_start");
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge CLK);
      if (i + 1 < 4) begin
        do_write(0, vecs[i+1].v0, st);
        do_write(1, vecs[i+1].v1, st);
        do_write(2, vecs[i+1].v2, st);
        CH_EN = vecs[i+1].en;
      end
      wait_fs($sformatf("vec%0d_fs", i));
      check($sformatf("vec%0d_w0", i), frame_w[0], vecs[i].w0);
      check($sformatf("vec%0d_w1", i), frame_w[1], vecs[i].w1);
      check($sformatf("vec%0d_w2", i), frame_w[2], vecs[i].w2);
      check($sformatf("vec%0d_period", i), period, FRAME);
    end

    // Mid-frame update and stall during COMMIT.
    repeat (5) @(negedge CLK);
    do_write(0, 100, st);
    CH_EN = 3'b111;
    wait_fs("p_fs");
    repeat (600) @(negedge CLK);
    do_write(0, 50, st);
    wait_fs("q_fs");
    check("midframe_cur_w0", frame_w[0], 1500);
    check("midframe_cur_w1", frame_w[1], 510);
    check("midframe_cur_w2", frame_w[2], 1500);
    do_write(0, 150, st);
    check("commit_stall_cycles", st, 1);
    wait_fs("r_fs");
    check("midframe_next_w0", frame_w[0], 1000);

    // Write accepted on the edge into COMMIT lands in that commit.
    n = 0;
    while (cyc != last_fs + FRAME - 1 && n < FRAME + 10) begin
      @(negedge CLK);
      n++;
    end
    check("pre_commit_align", int'(cyc == last_fs + FRAME - 1), 1);
    do_write(0, 30, st);
    check("pre_commit_stalls", st, 0);
    check("pre_commit_fs", int'(FRAME_START), 1);
    check("stalled_write_w0", frame_w[0], 2000);

    // Bad channel index.
    repeat (20) @(negedge CLK);
    do_write(3, 99, st);
    check("bad_ch_err_hi", int'(WR_ERR), 1);
    @(negedge CLK);
    check("bad_ch_err_lo", int'(WR_ERR), 0);
    wait_fs("t_fs");
    check("pre_commit_w0", frame_w[0], 800);
    fs_t = fs_cnt;

    // EN dropped during HEAD: frame completes, then idle.
    repeat (100) @(negedge CLK);
    EN = 1'b0;
    repeat (FRAME + 200) @(negedge CLK);
    check("en_drop_w0", hi_cnt[0], 800);
    check("en_drop_w1", hi_cnt[1], 510);
    check("en_drop_w2", hi_cnt[2], 1500);
    check("en_drop_no_fs", fs_cnt, fs_t);
    check("en_drop_pwm", int'(PWM_OUT), 0);

    // Asynchronous reset mid-pulse.
    EN = 1'b1;
    wait_fs("restart_fs");
    repeat (100) @(negedge CLK);
    check("pre_reset_pwm", int'(PWM_OUT), 7);
    #2 RST = 1'b1;
    #1;
    check("async_rst_pwm", int'(PWM_OUT), 0);
    check("async_rst_fs", int'(FRAME_START), 0);
    check("async_rst_ready", int'(WR_READY), 0);
    EN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rerelease_ready", int'(WR_READY), 1);
    fs0 = fs_cnt;
    repeat (50) @(negedge CLK);
    check("post_reset_pwm", int'(PWM_OUT), 0);
    check("post_reset_no_fs", fs_cnt, fs0);

    check("rise_after_fs_errors", gap_err, 0);
    check("rises_seen", int'(rise_cnt > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_servo_pwm_controller.md
# multi_servo_pwm_controller

Multi-channel servo PWM generator driving C_NUM_CH hobby servos from one shared 20 ms frame timer, so every channel's pulse starts on the same clock edge. Per-channel position words are written through a valid/ready port into shadow registers. All shadow registers are committed atomically at frame start, so no pulse is ever truncated or stretched mid-frame. It sits between the inverse-kinematics output stage and the leg servo pins and is the multi-leg successor of the single-channel servo PWM generator.

## Interface
- C_NUM_CH, 3: number of servo channels, 1..32.
- C_PWM_SIZE, 8: width of a position word.
- C_CLK_FREQ, 100: clock frequency in MHz.
- C_PWM_MAX_IN, 200: full-scale position value.
- C_MIN_US, 500: fixed leading high time in µs.
- C_SPAN_US, 2000: variable pulse span in µs at full scale.
- C_FRAME_US, 20000: frame period in µs.
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  global enable; sampled only at frame boundaries.
- CH_EN  in  C_NUM_CH  per-channel enable; latched at commit.
- WR_VALID  in  1  position write request.
- WR_READY  out  1  write accepted when WR_VALID && WR_READY at a rising edge.
- WR_CH  in  max(1,$clog2(C_NUM_CH))  target channel index.
- WR_DATA  in  C_PWM_SIZE  position value.
- WR_ERR  out  1  one-cycle pulse: accepted write had WR_CH >= C_NUM_CH (write discarded).
- FRAME_START  out  1  one-cycle pulse in the COMMIT cycle.
- PWM_OUT  out  C_NUM_CH  servo pulses, bit i = channel i.

## Operation
- Derived constants: HEAD = C_MIN_US*C_CLK_FREQ; STEP = C_SPAN_US*C_CLK_FREQ/C_PWM_MAX_IN; SPAN = C_PWM_MAX_IN*STEP; FRAME = C_FRAME_US*C_CLK_FREQ; TAIL = FRAME-1-HEAD-SPAN. FRAME > 1+HEAD+SPAN is required. Counter widths are $clog2 of the largest count.
- Per channel: a shadow register (written by the port), an active register, and an active-enable bit.
- Writes: WR_DATA > C_PWM_MAX_IN is clamped to C_PWM_MAX_IN before storing. A later write to the same channel overwrites the earlier one.
- FSM states: IDLE, COMMIT, HEAD, SPAN, TAIL.
- IDLE: counters are 0. EN=1 -> COMMIT.
- COMMIT (1 cycle): active <= shadow, active-enable <= CH_EN, FRAME_START=1, WR_READY=0. Then -> HEAD.
- HEAD: lasts HEAD cycles, then -> SPAN.
- SPAN: the step counter wraps every STEP cycles and increments the index counter (0..C_PWM_MAX_IN-1). After SPAN cycles -> TAIL.
- TAIL: lasts TAIL cycles. At the end, EN=1 -> COMMIT, else -> IDLE.
- PWM_OUT[i] next value:
  - HEAD: active-enable[i].
  - SPAN: active-enable[i] && index < active[i].
  - All other states: 0.
- Pulse width for channel i = HEAD + active[i]*STEP cycles. Defaults: 50,000 + v*1000 cycles (0.5–2.5 ms).
- EN deasserted mid-frame: the frame completes unchanged, then the FSM goes to IDLE. EN is ignored except at the end of TAIL and in IDLE.
- A CH_EN change mid-frame has no effect until the next COMMIT.
- WR_READY = 1 in every state except COMMIT and reset.

## Timing
- Reset (async assert): state=IDLE, all counters 0, all shadow/active registers 0, active-enable 0, PWM_OUT=0, FRAME_START=0, WR_ERR=0, WR_READY=0.
- Reset is released synchronously into IDLE. WR_READY=1 from the first clock edge after RST falls.
- Shadow updates on the accepting edge. A write accepted in the cycle before COMMIT is included in that commit. A write presented during COMMIT is stalled (WR_READY=0) and lands next cycle, taking effect the following frame.
- WR_ERR is registered: high the cycle after the accepting edge, for 1 cycle.
- PWM_OUT, FRAME_START and WR_READY are registered. Every PWM_OUT rising edge occurs exactly 1 cycle after the FRAME_START pulse.
- Rising-edge spacing between frames: exactly FRAME cycles while EN stays high.
- IDLE->COMMIT takes 1 cycle after EN is seen high.
- Reset mid-pulse: PWM_OUT is 0 immediately (asynchronous). No partial frame resumes.

## Test plan
(C_CLK_FREQ=1: HEAD=500, STEP=10, SPAN=2000, FRAME=20000)
- Reset values: assert RST mid-pulse -> all outputs 0 asynchronously. Release -> WR_READY=1 next edge, PWM_OUT stays 0 while EN=0.
- Single channel: write ch0=100, CH_EN=3'b001, EN=1 -> ch0 high 1500 cycles, period 20000. Ch1/ch2 stay 0. FRAME_START precedes each rise by 1 cycle.
- Boundaries and clamp: ch0=0, ch1=200, ch2=255 -> widths 500, 2500, 2500.
- Mid-frame update: write ch0=50 during SPAN of a 100-frame -> current pulse 1500, next pulse 1000. A write held during COMMIT -> WR_READY low 1 cycle, value applied the frame after.
- Bad channel: WR_CH=3 with C_NUM_CH=3 -> WR_ERR single pulse, all shadows unchanged.
- EN drop: deassert EN during HEAD -> that frame's pulses complete at full width, FSM reaches IDLE after TAIL, no further FRAME_START.
